// File: rtl/pkg_dtypes.sv
// Shared exec-unit datatypes: local-address/data words, the issued-op bundle and
// the operand-fetch FSM states.
package pkg_dtypes;

   localparam int ALU_LOCAL_ADDR_W = 8;
   localparam int EXEC_UNIT_DATA_W = 16;
   localparam int EU_OPC_W         = 4;

   typedef logic [ALU_LOCAL_ADDR_W-1:0] type_alu_local_addr;
   typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

   typedef struct packed {
      logic [EU_OPC_W-1:0] opcode;
      type_exec_unit_data  op0;
      type_exec_unit_data  op1;
      type_alu_local_addr  dest;
   } type_eu_issue_op;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } type_eu_fetch_state;

endpackage

// File: rtl/eu_operand_fetch_slot.sv
// One operand slot: holds a y-buffer read request until a response arrives after
// the read latency has elapsed, then captures the data exactly once.
module eu_operand_slot
   import pkg_dtypes::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_i,
   input  logic               fetch_i,
   input  logic               preset_got_i,
   input  type_exec_unit_data preset_data_i,
   input  logic               success_i,
   input  type_exec_unit_data data_i,
   output logic               req_valid_o,
   output logic               got_o,
   output logic               got_next_o,
   output type_exec_unit_data data_o
);

   localparam int LAT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;

   logic [LAT_W-1:0]   lat_q, lat_d;
   logic               got_q, got_d;
   type_exec_unit_data data_q, data_d;
   logic               lat_open;
   logic               capture;

   always_comb begin
      lat_open = (int'(lat_q) >= RD_LATENCY);
      capture  = fetch_i & lat_open & success_i & ~got_q;
      lat_d    = lat_q;
      got_d    = got_q;
      data_d   = data_q;
      if (start_i) begin
         lat_d  = '0;
         got_d  = preset_got_i;
         data_d = preset_data_i;
      end else begin
         if (fetch_i && !lat_open) begin
            lat_d = lat_q + LAT_W'(1);
         end
         // A captured operand is frozen until the next op starts.
         if (capture) begin
            got_d  = 1'b1;
            data_d = data_i;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lat_q  <= '0;
         got_q  <= 1'b0;
         data_q <= '0;
      end else begin
         lat_q  <= lat_d;
         got_q  <= got_d;
         data_q <= data_d;
      end
   end

   assign req_valid_o = fetch_i & ~got_q;
   assign got_o       = got_q;
   assign got_next_o  = got_d;
   assign data_o      = data_q;

endmodule

// File: rtl/eu_operand_fetch.sv
// Operand-fetch issue stage: accepts one decoded op, fetches op0/op1 from the
// y-buffer with unlimited retries, then offers the complete op to the ALU.
module eu_operand_fetch
   import pkg_dtypes::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int OPC_WIDTH  = EU_OPC_W,
   parameter int STALL_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   input  logic [OPC_WIDTH-1:0]  instr_opcode_i,
   input  type_alu_local_addr    instr_op0_addr_i,
   input  type_alu_local_addr    instr_op1_addr_i,
   input  logic                  instr_op1_is_imm_i,
   input  type_exec_unit_data    instr_imm_i,
   input  type_alu_local_addr    instr_dest_addr_i,
   output type_alu_local_addr    op0_req_addr_o,
   output logic                  op0_req_addr_valid_o,
   output type_alu_local_addr    op1_req_addr_o,
   output logic                  op1_req_addr_valid_o,
   input  type_exec_unit_data    op0_data_i,
   input  logic                  op0_data_success_i,
   input  type_exec_unit_data    op1_data_i,
   input  logic                  op1_data_success_i,
   output logic                  alu_valid_o,
   input  logic                  alu_ready_i,
   output logic [OPC_WIDTH-1:0]  alu_opcode_o,
   output type_exec_unit_data    alu_op0_o,
   output type_exec_unit_data    alu_op1_o,
   output type_alu_local_addr    alu_dest_addr_o,
   output logic [STALL_BITS-1:0] stall_count_o,
   output type_eu_fetch_state    state_dbg_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high; valid never depends on ready, and payload is held while valid waits.

   type_eu_fetch_state    state_q, state_d;
   logic [OPC_WIDTH-1:0]  opcode_q, opcode_d;
   type_alu_local_addr    op0_addr_q, op0_addr_d;
   type_alu_local_addr    op1_addr_q, op1_addr_d;
   type_alu_local_addr    dest_q, dest_d;
   logic [STALL_BITS-1:0] stall_q, stall_d;

   logic               start;
   logic               fetch;
   logic               got0, got1, got0_next, got1_next;
   type_exec_unit_data op0_data, op1_data;
   type_eu_issue_op    issue_op;

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      op0_addr_d    = op0_addr_q;
      op1_addr_d    = op1_addr_q;
      dest_d        = dest_q;
      stall_d       = stall_q;
      start         = 1'b0;
      fetch         = 1'b0;
      instr_ready_o = 1'b0;
      alu_valid_o   = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready_o = 1'b1;
            if (instr_valid_i) begin
               start      = 1'b1;
               opcode_d   = instr_opcode_i;
               op0_addr_d = instr_op0_addr_i;
               op1_addr_d = instr_op1_addr_i;
               dest_d     = instr_dest_addr_i;
               stall_d    = '0;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            fetch = 1'b1;
            if (stall_q != '1) begin
               stall_d = stall_q + STALL_BITS'(1);
            end
            // Same-cycle capture of the last outstanding operand still issues next.
            if (got0_next && got1_next) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            alu_valid_o = 1'b1;
            if (alu_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         opcode_q   <= '0;
         op0_addr_q <= '0;
         op1_addr_q <= '0;
         dest_q     <= '0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         opcode_q   <= opcode_d;
         op0_addr_q <= op0_addr_d;
         op1_addr_q <= op1_addr_d;
         dest_q     <= dest_d;
         stall_q    <= stall_d;
      end
   end

   eu_operand_slot #(.RD_LATENCY(RD_LATENCY)) u_slot0 (
      .clk           (clk),
      .reset_n       (reset_n),
      .start_i       (start),
      .fetch_i       (fetch),
      .preset_got_i  (1'b0),
      .preset_data_i ('0),
      .success_i     (op0_data_success_i),
      .data_i        (op0_data_i),
      .req_valid_o   (op0_req_addr_valid_o),
      .got_o         (got0),
      .got_next_o    (got0_next),
      .data_o        (op0_data)
   );

   // An immediate op1 is preloaded as already captured, so only op0 is fetched.
   eu_operand_slot #(.RD_LATENCY(RD_LATENCY)) u_slot1 (
      .clk           (clk),
      .reset_n       (reset_n),
      .start_i       (start),
      .fetch_i       (fetch),
      .preset_got_i  (instr_op1_is_imm_i),
      .preset_data_i (instr_op1_is_imm_i ? instr_imm_i : '0),
      .success_i     (op1_data_success_i),
      .data_i        (op1_data_i),
      .req_valid_o   (op1_req_addr_valid_o),
      .got_o         (got1),
      .got_next_o    (got1_next),
      .data_o        (op1_data)
   );

   always_comb begin
      issue_op.opcode = EU_OPC_W'(opcode_q);
      issue_op.op0    = op0_data;
      issue_op.op1    = op1_data;
      issue_op.dest   = dest_q;
   end

   assign op0_req_addr_o  = op0_addr_q;
   assign op1_req_addr_o  = op1_addr_q;
   assign alu_opcode_o    = OPC_WIDTH'(issue_op.opcode);
   assign alu_op0_o       = issue_op.op0;
   assign alu_op1_o       = issue_op.op1;
   assign alu_dest_addr_o = issue_op.dest;
   assign stall_count_o   = stall_q;
   assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_eu_operand_fetch.sv
// Bench for eu_operand_fetch: y-buffer responder driven from per-op success
// schedules, expected ALU ops queued at issue and checked at the ALU handshake.
module tb_eu_operand_fetch;
   import pkg_dtypes::*;

   localparam int RD_LAT  = 1;
   localparam int OPC_W   = 4;
   localparam int STALL_W = 8;
   localparam int STALL_MAX = (1 << STALL_W) - 1;
   localparam int EXP_W   = OPC_W + 16 + 16 + 8 + STALL_W;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic instr_valid_i = 1'b0;
   logic instr_ready_o;
   logic [OPC_W-1:0] instr_opcode_i = '0;
   type_alu_local_addr instr_op0_addr_i = '0, instr_op1_addr_i = '0, instr_dest_addr_i = '0;
   logic instr_op1_is_imm_i = 1'b0;
   type_exec_unit_data instr_imm_i = '0;
   type_alu_local_addr op0_req_addr_o, op1_req_addr_o;
   logic op0_req_addr_valid_o, op1_req_addr_valid_o;
   type_exec_unit_data op0_data_i = '0, op1_data_i = '0;
   logic op0_data_success_i = 1'b0, op1_data_success_i = 1'b0;
   logic alu_valid_o;
   logic alu_ready_i = 1'b0;
   logic [OPC_W-1:0] alu_opcode_o;
   type_exec_unit_data alu_op0_o, alu_op1_o;
   type_alu_local_addr alu_dest_addr_o;
   logic [STALL_W-1:0] stall_count_o;
   type_eu_fetch_state state_dbg_o;

   eu_operand_fetch #(.RD_LATENCY(RD_LAT), .OPC_WIDTH(OPC_W), .STALL_BITS(STALL_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
      .instr_opcode_i(instr_opcode_i), .instr_op0_addr_i(instr_op0_addr_i),
      .instr_op1_addr_i(instr_op1_addr_i), .instr_op1_is_imm_i(instr_op1_is_imm_i),
      .instr_imm_i(instr_imm_i), .instr_dest_addr_i(instr_dest_addr_i),
      .op0_req_addr_o(op0_req_addr_o), .op0_req_addr_valid_o(op0_req_addr_valid_o),
      .op1_req_addr_o(op1_req_addr_o), .op1_req_addr_valid_o(op1_req_addr_valid_o),
      .op0_data_i(op0_data_i), .op0_data_success_i(op0_data_success_i),
      .op1_data_i(op1_data_i), .op1_data_success_i(op1_data_success_i),
      .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
      .alu_opcode_o(alu_opcode_o), .alu_op0_o(alu_op0_o), .alu_op1_o(alu_op1_o),
      .alu_dest_addr_o(alu_dest_addr_o), .stall_count_o(stall_count_o),
      .state_dbg_o(state_dbg_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [EXP_W-1:0] exp_q[$];
   type_exec_unit_data mem[256];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // scoreboard monitor: compares at each ALU handshake, checks hold while stalled
   logic [EXP_W-1:0] mon_cur, mon_snap;
   logic mon_held = 1'b0;
   always @(negedge clk) begin
      if (reset_n && alu_valid_o) begin
         mon_cur = {alu_opcode_o, alu_op0_o, alu_op1_o, alu_dest_addr_o, stall_count_o};
         if (mon_held) check("alu_stable", mon_cur, mon_snap);
         if (alu_ready_i) begin
            check("exp_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("alu_op", mon_cur, exp_q.pop_front());
            mon_held = 1'b0;
         end else begin
            mon_snap = mon_cur;
            mon_held = 1'b1;
         end
      end else begin
         mon_held = 1'b0;
      end
   end

   // y-buffer response for fetch cycle i given the cycle s at which the correct data arrives
   task automatic resp(input int i, input int s, input type_exec_unit_data v, input logic bogus,
                       output logic succ, output type_exec_unit_data data);
      if (i < RD_LAT) begin
         succ = bogus;
         data = ~v;
      end else if (i < s) begin
         succ = 1'b0;
         data = 16'($urandom);
      end else if (i == s) begin
         succ = 1'b1;
         data = v;
      end else begin
         succ = 1'($urandom);
         data = ~v;
      end
   endtask

   // driver: called just after a rising edge with the DUT idle
   task automatic run_op(input logic [OPC_W-1:0] opc, input type_alu_local_addr a0, a1, dest,
                         input type_exec_unit_data v0, v1, input logic imm,
                         input type_exec_unit_data immv, input int s0, s1,
                         input logic bogus, input int d);
      int len;
      int st;
      type_exec_unit_data e1;
      len = imm ? s0 + 1 : ((s0 > s1 ? s0 : s1) + 1);
      st  = (len > STALL_MAX) ? STALL_MAX : len;
      e1  = imm ? immv : v1;
      exp_q.push_back({opc, v0, e1, dest, STALL_W'(st)});
      check("instr_ready_idle", instr_ready_o, 1);
      instr_valid_i = 1'b1;
      instr_opcode_i = opc;
      instr_op0_addr_i = a0;
      instr_op1_addr_i = a1;
      instr_dest_addr_i = dest;
      instr_op1_is_imm_i = imm;
      instr_imm_i = immv;
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         instr_valid_i = 1'b0;
         check("op0_req_valid", op0_req_addr_valid_o, i <= s0);
         if (i <= s0) check("op0_req_addr", op0_req_addr_o, a0);
         check("op1_req_valid", op1_req_addr_valid_o, !imm && i <= s1);
         if (!imm && i <= s1) check("op1_req_addr", op1_req_addr_o, a1);
         check("stall_fetch", stall_count_o, (i > STALL_MAX) ? STALL_MAX : i);
         check("alu_valid_fetch", alu_valid_o, 0);
         check("instr_ready_fetch", instr_ready_o, 0);
         resp(i, s0, v0, bogus, op0_data_success_i, op0_data_i);
         resp(i, imm ? -1 : s1, v1, bogus, op1_data_success_i, op1_data_i);
      end
      for (int j = 0; j <= d; j++) begin
         @(posedge clk); #1;
         op0_data_success_i = 1'b0;
         op1_data_success_i = 1'b0;
         check("alu_valid_issue", alu_valid_o, 1);
         check("instr_ready_issue", instr_ready_o, 0);
         check("reqs_issue", {op0_req_addr_valid_o, op1_req_addr_valid_o}, 0);
         alu_ready_i = (j == d);
         instr_valid_i = (j < d);
         if (j < d) begin
            instr_opcode_i = 4'($urandom);
            instr_op0_addr_i = 8'($urandom);
            instr_dest_addr_i = 8'($urandom);
         end
      end
      @(posedge clk); #1;
      alu_ready_i = 1'b0;
      instr_valid_i = 1'b0;
      check("alu_valid_done", alu_valid_o, 0);
      check("instr_ready_done", instr_ready_o, 1);
   endtask

   task automatic pulse_reset_check(input string tag);
      #2 reset_n = 1'b0;
      #1;
      check({tag, "_reqs"}, {op0_req_addr_valid_o, op1_req_addr_valid_o}, 0);
      check({tag, "_alu_valid"}, alu_valid_o, 0);
      check({tag, "_instr_ready"}, instr_ready_o, 1);
      check({tag, "_stall"}, stall_count_o, 0);
      check({tag, "_alu_op0"}, alu_op0_o, 0);
      op0_data_success_i = 1'b0;
      op1_data_success_i = 1'b0;
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check({tag, "_post_ready"}, instr_ready_o, 1);
      check({tag, "_post_stall"}, stall_count_o, 0);
      check({tag, "_post_alu_valid"}, alu_valid_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("rst_instr_ready", instr_ready_o, 1);
      check("rst_alu_valid", alu_valid_o, 0);
      check("rst_reqs", {op0_req_addr_valid_o, op1_req_addr_valid_o}, 0);
      check("rst_stall", stall_count_o, 0);
      check("rst_alu_fields", {alu_opcode_o, alu_op0_o, alu_op1_o, alu_dest_addr_o}, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // both operands at the first legal cycle
      run_op(4'h3, 8'h10, 8'h20, 8'h30, 16'h0011, 16'h0022, 1'b0, 16'h0, RD_LAT, RD_LAT, 1'b0, 0);
      // op0 in the 2nd fetch cycle, op1 in the 6th
      run_op(4'h5, 8'h01, 8'h02, 8'h03, mem[1], mem[2], 1'b0, 16'h0, 1, 5, 1'b0, 0);
      // immediate op1
      run_op(4'h7, 8'h40, 8'h41, 8'h42, mem[8'h40], mem[8'h41], 1'b1, 16'h00AB, RD_LAT, 0, 1'b0, 0);
      // ALU stalls 5 cycles while another op is offered
      run_op(4'h9, 8'h50, 8'h51, 8'h52, mem[8'h50], mem[8'h51], 1'b0, 16'h0, 2, 1, 1'b0, 5);
      // early success pulses with wrong data
      run_op(4'hA, 8'h60, 8'h61, 8'h62, mem[8'h60], mem[8'h61], 1'b0, 16'h0, 3, 2, 1'b1, 0);
      // same address on both operands
      run_op(4'hB, 8'h70, 8'h70, 8'h71, mem[8'h70], mem[8'h70], 1'b0, 16'h0, 2, 4, 1'b0, 1);
      // stall counter saturation
      run_op(4'hC, 8'h80, 8'h81, 8'h82, mem[8'h80], mem[8'h81], 1'b0, 16'h0, 300, 2, 1'b0, 0);

      for (int n = 0; n < 30; n++) begin
         type_alu_local_addr a0, a1;
         logic imm;
         a0 = 8'($urandom);
         a1 = ($urandom_range(0, 4) == 0) ? a0 : 8'($urandom);
         imm = ($urandom_range(0, 3) == 0);
         run_op(4'($urandom), a0, a1, 8'($urandom), mem[a0], mem[a1], imm, 16'($urandom),
                $urandom_range(RD_LAT, RD_LAT + 4), $urandom_range(RD_LAT, RD_LAT + 4),
                1'($urandom), $urandom_range(0, 3));
      end

      // reset during FETCH
      check("instr_ready_pre_reset", instr_ready_o, 1);
      instr_valid_i = 1'b1;
      instr_op1_is_imm_i = 1'b0;
      @(posedge clk); #1;
      instr_valid_i = 1'b0;
      @(posedge clk); #1;
      check("fetch_req_before_reset", op0_req_addr_valid_o, 1);
      pulse_reset_check("rst_fetch");

      // reset during ISSUE
      instr_valid_i = 1'b1;
      @(posedge clk); #1;
      instr_valid_i = 1'b0;
      @(posedge clk); #1;
      op0_data_success_i = 1'b1;
      op0_data_i = 16'h1234;
      op1_data_success_i = 1'b1;
      op1_data_i = 16'h5678;
      @(posedge clk); #1;
      op0_data_success_i = 1'b0;
      op1_data_success_i = 1'b0;
      check("issue_before_reset", alu_valid_o, 1);
      pulse_reset_check("rst_issue");

      repeat (2) @(posedge clk);
      #1;
      check("exp_q_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
